// File: rtl/gfx_fixed_pkg.sv
// Q16.16 fixed-point types and helpers shared by the geometry pipeline stages.
package gfx_fixed_pkg;

    typedef logic signed [31:0] fixed_t;
    typedef fixed_t [3:0] vec4_t;

    localparam int FRAC_BITS = 16;
    localparam fixed_t FIX_ONE = fixed_t'(32'd1 << FRAC_BITS);

    // True when |v| > 1.0; exactly +/-1.0 is still inside.
    function automatic logic fix_exceeds_one(fixed_t v);
        return (v > FIX_ONE) || (v < -FIX_ONE);
    endfunction

endpackage

// File: rtl/recip_divider.sv
// Serial restoring divider computing floor(2^WIDTH / divisor), one quotient bit per cycle.
module recip_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int unsigned ITERS = WIDTH + 1;
    localparam int unsigned CW    = $clog2(ITERS + 1);

    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_shift, rem_sub;
    logic             ge;

    // The dividend is a single 1 followed by WIDTH zeros, so only the first step shifts in a 1.
    always_comb begin
        rem_shift = {rem_q, cnt_q == CW'(ITERS)};
        rem_sub   = rem_shift - {1'b0, div_q};
        ge        = ~rem_sub[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= divisor;
            cnt_q <= CW'(ITERS);
        end else if (cnt_q != '0) begin
            rem_q <= ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ge};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign quotient = quo_q;
    assign done     = (cnt_q == CW'(1));

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide and viewport transform: clip-space (x,y,z,w) to NDC, pixel and clip flag.
module perspective_divide
    import gfx_fixed_pkg::*;
#(
    parameter int unsigned             WIDTH    = 32,
    parameter int unsigned             FRAC     = 16,
    parameter int unsigned             SCREEN_W = 320,
    parameter int unsigned             SCREEN_H = 180,
    parameter logic signed [WIDTH-1:0] W_MIN    = 32'h0000_0100
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               start,
    input  logic signed [3:0][WIDTH-1:0]       v_in,
    output logic signed [2:0][WIDTH-1:0]       ndc_out,
    output logic        [$clog2(SCREEN_W)-1:0] px_out,
    output logic        [$clog2(SCREEN_H)-1:0] py_out,
    output logic                               clipped,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned PXW = $clog2(SCREEN_W);
    localparam int unsigned PYW = $clog2(SCREEN_H);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic signed [PW-1:0] HALF_W = PW'(SCREEN_W / 2);
    localparam logic signed [PW-1:0] HALF_H = PW'(SCREEN_H / 2);
    localparam logic signed [PW-1:0] PX_MAX = PW'(SCREEN_W - 1);
    localparam logic signed [PW-1:0] PY_MAX = PW'(SCREEN_H - 1);

    typedef enum logic [2:0] {StIdle, StDiv, StMul, StView, StRej, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             div_start, div_done;
    logic [WIDTH-1:0] recip;
    fixed_t           x_q, y_q, z_q, nx_q, ny_q, nz_q;
    fixed_t           mul_a, mul_res;
    logic signed [PW-1:0] prod, prod_sh, px_sh, py_sh;
    logic [PXW-1:0]   px_v;
    logic [PYW-1:0]   py_v;
    logic             clip_v, w_low;

    assign w_low = $signed(v_in[3]) < W_MIN;
    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign done  = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    cnt_d = '0;
                    if (w_low) begin
                        state_d = StRej;
                    end else begin
                        state_d   = StDiv;
                        div_start = 1'b1;
                    end
                end
            end
            StDiv: begin
                if (div_done) begin
                    state_d = StMul;
                    cnt_d   = '0;
                end
            end
            StMul: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 2'd2) state_d = StView;
            end
            StView: state_d = StDone;
            // Reject path is padded to two cycles so done lands two edges after start.
            StRej: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 2'd1) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    recip_divider #(
        .WIDTH(WIDTH)
    ) u_recip (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .start   (div_start),
        .divisor (v_in[3]),
        .quotient(recip),
        .done    (div_done)
    );

    // Single shared multiplier, stepped across x, y, z during MUL.
    always_comb begin
        unique case (cnt_q)
            2'd0:    mul_a = x_q;
            2'd1:    mul_a = y_q;
            default: mul_a = z_q;
        endcase
        prod    = PW'(mul_a) * PW'($signed(recip));
        prod_sh = prod >>> FRAC;
        if (&prod_sh[PW-1:WIDTH-1] || ~|prod_sh[PW-1:WIDTH-1]) begin
            mul_res = prod_sh[WIDTH-1:0];
        end else begin
            mul_res = prod_sh[PW-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
    end

    always_comb begin
        px_sh = ((PW'(nx_q) + PW'(FIX_ONE)) * HALF_W) >>> FRAC;
        py_sh = ((PW'(FIX_ONE) - PW'(ny_q)) * HALF_H) >>> FRAC;
        if (px_sh < 0)           px_v = '0;
        else if (px_sh > PX_MAX) px_v = PX_MAX[PXW-1:0];
        else                     px_v = px_sh[PXW-1:0];
        if (py_sh < 0)           py_v = '0;
        else if (py_sh > PY_MAX) py_v = PY_MAX[PYW-1:0];
        else                     py_v = py_sh[PYW-1:0];
        clip_v = fix_exceeds_one(nx_q) | fix_exceeds_one(ny_q) | fix_exceeds_one(nz_q);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            nz_q    <= '0;
            ndc_out <= '0;
            px_out  <= '0;
            py_out  <= '0;
            clipped <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (div_start) begin
                x_q <= v_in[0];
                y_q <= v_in[1];
                z_q <= v_in[2];
            end
            if (state_q == StMul) begin
                unique case (cnt_q)
                    2'd0:    nx_q <= mul_res;
                    2'd1:    ny_q <= mul_res;
                    default: nz_q <= mul_res;
                endcase
            end
            if (state_q == StView) begin
                ndc_out <= {nz_q, ny_q, nx_q};
                px_out  <= px_v;
                py_out  <= py_v;
                clipped <= clip_v;
            end
            if (state_q == StRej && cnt_q == 2'd1) begin
                ndc_out <= '0;
                px_out  <= '0;
                py_out  <= '0;
                clipped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_perspective_divide.sv
// Directed-vector bench for perspective_divide: latency, results, reject, robustness, reset.
module tb_perspective_divide;

    localparam logic [127:0] V_BASIC = {32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000};
    localparam logic [127:0] V_NEG   = {32'h0004_0000, 32'h0, 32'h0, 32'hFFF8_0000};
    localparam logic [127:0] V_FRAC  = {32'h0003_0000, 32'h0, 32'h0, 32'h0001_8000};
    localparam logic [127:0] V_ZERO  = 128'h0;
    localparam logic [95:0]  E_BASIC = {32'h0000_4000, 32'h0000_8000, 32'h0001_0000};
    localparam logic [95:0]  E_NEG   = {32'h0, 32'h0, 32'hFFFE_0000};
    localparam logic [95:0]  E_FRAC  = {32'h0, 32'h0, 32'h0000_7FFF};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0][31:0]  v_in = '0;
    logic [2:0][31:0]  ndc_out;
    logic [8:0]        px_out;
    logic [7:0]        py_out;
    logic              clipped, busy, done;

    int vectors = 0;
    int miscompares = 0;

    perspective_divide dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .start   (start),
        .v_in    (v_in),
        .ndc_out (ndc_out),
        .px_out  (px_out),
        .py_out  (py_out),
        .clipped (clipped),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen (or after a bound).
    task automatic run_op(input logic [127:0] v, output int lat, output int busy_cyc);
        v_in = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_scripted(input logic [127:0] v, input int hold, input int pulse_at,
                                input int change_at, input logic [127:0] alt,
                                output int first, output int pulses);
        v_in = v;
        start = 1'b1;
        first = -1;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            start = (i < hold - 1) || (i == pulse_at);
            if (i == change_at) v_in = alt;
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (ndc_out !== 96'h0) begin miscompares++;
            $display("FAIL reset_ndc: got %h expected 0", ndc_out); end
        vectors++; if ({px_out, py_out, clipped, busy, done} !== 20'h0) begin miscompares++;
            $display("FAIL reset_ctl: got px=%0d py=%0d clip=%b busy=%b done=%b expected all 0",
                     px_out, py_out, clipped, busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(V_BASIC, lat, bc);
        vectors++; if (lat !== 37) begin miscompares++;
            $display("FAIL basic_latency: got %0d expected 37", lat); end
        vectors++; if (bc !== 37) begin miscompares++;
            $display("FAIL basic_busy: got %0d expected 37", bc); end
        vectors++; if (ndc_out !== E_BASIC) begin miscompares++;
            $display("FAIL basic_ndc: got %h expected %h", ndc_out, E_BASIC); end
        vectors++; if (px_out !== 9'd319 || py_out !== 8'd45 || clipped !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_view: got px=%0d py=%0d clip=%b expected 319 45 0",
                     px_out, py_out, clipped); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || ndc_out !== E_BASIC) begin miscompares++;
            $display("FAIL basic_pulse: got done=%b ndc=%h expected 0 %h", done, ndc_out,
                     E_BASIC); end
    endtask

    task automatic test_frac();
        int lat, bc;
        run_op(V_FRAC, lat, bc);
        vectors++; if (ndc_out !== E_FRAC || lat !== 37) begin miscompares++;
            $display("FAIL frac_ndc: got %h lat %0d expected %h lat 37", ndc_out, lat, E_FRAC); end
        vectors++; if (px_out !== 9'd239 || py_out !== 8'd90 || clipped !== 1'b0) begin
            miscompares++;
            $display("FAIL frac_view: got px=%0d py=%0d clip=%b expected 239 90 0",
                     px_out, py_out, clipped); end
        @(negedge clk);
    endtask

    task automatic test_reject();
        logic [31:0] ws [3] = '{32'h0, 32'hFFFF_0000, 32'h0000_00FF};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op({ws[i], 32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, lat, bc);
            vectors++; if (lat !== 2 || bc !== 2) begin miscompares++;
                $display("FAIL reject_latency[%0d]: got lat %0d busy %0d expected 2 2", i, lat,
                         bc); end
            vectors++; if (ndc_out !== 96'h0 || px_out !== 9'd0 || py_out !== 8'd0
                           || clipped !== 1'b1) begin miscompares++;
                $display("FAIL reject_out[%0d]: got %h px=%0d py=%0d clip=%b expected 0 0 0 1",
                         i, ndc_out, px_out, py_out, clipped); end
        end
        @(negedge clk);
    endtask

    task automatic test_negative_clamp();
        int lat, bc;
        run_op(V_NEG, lat, bc);
        vectors++; if (ndc_out !== E_NEG || lat !== 37) begin miscompares++;
            $display("FAIL neg_ndc: got %h lat %0d expected %h lat 37", ndc_out, lat, E_NEG); end
        vectors++; if (px_out !== 9'd0 || py_out !== 8'd90 || clipped !== 1'b1) begin
            miscompares++;
            $display("FAIL neg_view: got px=%0d py=%0d clip=%b expected 0 90 1",
                     px_out, py_out, clipped); end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int first, pulses;
        run_scripted(V_FRAC, 3, -1, -1, V_FRAC, first, pulses);
        vectors++; if (first !== 37 || pulses !== 1) begin miscompares++;
            $display("FAIL held_start: got first %0d pulses %0d expected 37 1", first, pulses); end
        vectors++; if (ndc_out !== E_FRAC) begin miscompares++;
            $display("FAIL held_ndc: got %h expected %h", ndc_out, E_FRAC); end
    endtask

    task automatic test_start_during_div();
        int first, pulses;
        run_scripted(V_BASIC, 1, 10, 10, V_ZERO, first, pulses);
        vectors++; if (first !== 37 || pulses !== 1) begin miscompares++;
            $display("FAIL div_start: got first %0d pulses %0d expected 37 1", first, pulses); end
        vectors++; if (ndc_out !== E_BASIC || clipped !== 1'b0) begin miscompares++;
            $display("FAIL div_start_ndc: got %h clip=%b expected %h 0", ndc_out, clipped,
                     E_BASIC); end
    endtask

    task automatic test_vin_change();
        int first, pulses;
        run_scripted(V_NEG, 1, -1, 0, V_BASIC, first, pulses);
        vectors++; if (first !== 37 || ndc_out !== E_NEG || px_out !== 9'd0) begin
            miscompares++;
            $display("FAIL vin_change: got first %0d ndc %h px %0d expected 37 %h 0", first,
                     ndc_out, px_out, E_NEG); end
    endtask

    task automatic test_reset_mid_div();
        int lat, bc, pulses;
        v_in = V_BASIC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (ndc_out !== 96'h0 || py_out !== 8'd0 || clipped !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_out: got %h py=%0d clip=%b expected 0 0 0", ndc_out, py_out,
                     clipped); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL midreset_ctl: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++;
            $display("FAIL midreset_nodone: got %0d pulses expected 0", pulses); end
        run_op(V_FRAC, lat, bc);
        vectors++; if (lat !== 37 || ndc_out !== E_FRAC || px_out !== 9'd239) begin
            miscompares++;
            $display("FAIL midreset_after: got lat %0d ndc %h px %0d expected 37 %h 239", lat,
                     ndc_out, px_out, E_FRAC); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(V_BASIC, lat, bc);
        vectors++; if (ndc_out !== E_BASIC) begin miscompares++;
            $display("FAIL b2b_first: got %h expected %h", ndc_out, E_BASIC); end
        run_op(V_NEG, lat, bc);
        vectors++; if (lat !== 37 || bc !== 37) begin miscompares++;
            $display("FAIL b2b_latency: got lat %0d busy %0d expected 37 37", lat, bc); end
        vectors++; if (ndc_out !== E_NEG || py_out !== 8'd90 || clipped !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got %h py=%0d clip=%b expected %h 90 1", ndc_out, py_out,
                     clipped, E_NEG); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frac();
        test_reject();
        test_negative_clamp();
        test_start_held();
        test_start_during_div();
        test_vin_change();
        test_reset_mid_div();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perspective_divide.md
Name: perspective_divide

Overview:
- Downstream stage of the 4x4 matrix-vector multiplier. Consumes the clip-space vector (x, y, z, w) in Q16.16 and produces:
  - NDC coordinates x/w, y/w, z/w;
  - integer screen pixel coordinates;
  - a clip flag.
- Computes one reciprocal 1/w with a serial divider, then uses one shared multiplier three times, then applies the viewport transform.
- Its start is driven by the upstream done.

Parameters:
- WIDTH, 32, fixed-point word width.
- FRAC, 16, fractional bits (Q16.16).
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 180, screen height in pixels.
- W_MIN, 32'h0000_0100, smallest accepted w (1/256); any w below it is trivially rejected.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; latches v_in.
- v_in  in  [3:0][WIDTH-1:0] signed  {x,y,z,w} with index 0 = x and index 3 = w.
- ndc_out  out  [2:0][WIDTH-1:0] signed  {x/w, y/w, z/w} in Q16.16.
- px_out  out  $clog2(SCREEN_W)  pixel column.
- py_out  out  $clog2(SCREEN_H)  pixel row.
- clipped  out  1  vertex is outside the view volume or w is below W_MIN.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the outputs are valid.

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; all outputs 0; the internal divider is cleared. Reset mid-operation aborts the operation with no done pulse.
- start is accepted only when busy=0, i.e. in IDLE or the DONE cycle. It is ignored while busy. On acceptance, v_in is latched; later changes to v_in have no effect.
- States: IDLE -> DIV -> MUL -> VIEW -> DONE -> IDLE.
  - From IDLE or DONE with start and w < W_MIN (signed compare, covers w<=0): go to REJ -> DONE.
  - From DONE with a valid start: go directly to DIV (back-to-back operation).
- DIV, 33 cycles: unsigned restoring divide, one quotient bit per cycle, of 2^32 by w.
  - recip = floor(2^32 / w_raw) = 1/w in Q16.16.
  - w >= W_MIN guarantees recip <= 2^24, so there is no overflow.
- MUL, 3 cycles, one per component c = x, y, z:
  - p = c * recip, signed 64-bit product;
  - ndc_c = p[47:16] (arithmetic truncation toward -inf);
  - saturate to 32'h7FFF_FFFF / 32'h8000_0000 if p[63:47] is not uniform sign.
- VIEW, 1 cycle:
  - px = ((ndc_x + 1.0) * (SCREEN_W/2)) >>> 16, clamped to [0, SCREEN_W-1].
  - py = ((1.0 - ndc_y) * (SCREEN_H/2)) >>> 16, clamped to [0, SCREEN_H-1].
  - Use 64-bit intermediates.
  - clipped = 1 if |ndc_x|, |ndc_y| or |ndc_z| > 1.0 (strictly greater; exactly ±1.0 is not clipped).
- REJ: ndc_out = 0, px_out = 0, py_out = 0, clipped = 1.
- Latency, with start sampled at edge k:
  - normal path: busy=1 from k through k+36; done=1 for the single cycle after edge k+37;
  - reject path: done after edge k+2.
  - Outputs are updated at the edge where done rises and are held until the next done.
- busy=0 in IDLE and DONE; busy=1 in every other state.

Decomposition:
- Package gfx_fixed_pkg:
  - typedef fixed_t (logic signed [31:0]);
  - typedef vec4_t ([3:0] fixed_t);
  - FRAC_BITS = 16;
  - FIX_ONE = 32'h0001_0000.
  - Shared with the matrix-vector multiplier.
- Sub-module recip_divider:
  - serial 33-iteration restoring divider;
  - ports: start, divisor, quotient, done;
  - instantiated once.
- The FSM, the shared multiplier and the viewport logic stay in perspective_divide.

Test Plan:
- v_in = {2.0, 1.0, 0.5, 2.0} (x,y,z,w) -> recip 0x8000; ndc = {0x0001_0000, 0x0000_8000, 0x0000_4000}; px=319 (320 clamped), py=45, clipped=0; done exactly 37 cycles after start.
- w=0 (and w=-1.0, and w=0x0000_00FF) -> done 2 cycles after start; ndc/px/py = 0, clipped=1, busy never high beyond REJ.
- v_in = {-8.0, 0, 0, 4.0} -> ndc_x = 0xFFFE_0000 (-2.0), px=0 (clamped), py=90, clipped=1.
- v_in = {1.5, 0, 0, 3.0} -> recip 0x5555; ndc_x = 0x0000_7FFF; px=239, py=90, clipped=0.
- Robustness:
  - start held high 3 cycles -> exactly one operation;
  - start pulsed during DIV -> ignored;
  - v_in changed after start -> result unchanged.
- Reset and back-to-back:
  - rst_n_in low mid-DIV -> all outputs 0 immediately, no done pulse;
  - a new start afterwards gives the correct result;
  - start in the done cycle -> second done exactly 37 cycles later.
